// File: rtl/mmio_controller_pkg.sv
// mmio_controller_pkg: I/O address map, field widths, debouncer states and hex glyph decode
package mmio_controller_pkg;
  localparam logic [31:0] ADDR_HEX  = 32'hF0000000;
  localparam logic [31:0] ADDR_LEDR = 32'hF0000004;
  localparam logic [31:0] ADDR_LEDG = 32'hF0000008;
  localparam logic [31:0] ADDR_KEY  = 32'hF0000010;
  localparam logic [31:0] ADDR_SW   = 32'hF0000014;
  localparam int HEX_W  = 16;
  localparam int LEDR_W = 10;
  localparam int LEDG_W = 8;
  localparam int KEY_W  = 4;
  localparam int SW_W   = 10;
  typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction
endpackage

// File: rtl/mmio_controller_debouncer.sv
// mmio_controller_debouncer: 2-flop synchronizer plus counting debouncer for one input bit
module mmio_controller_debouncer
  import mmio_controller_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 20,
  parameter logic [DEBOUNCE_BITS-1:0] DEBOUNCE_CYCLES = DEBOUNCE_BITS'(500000),
  parameter logic INV = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);
  logic s1, s2, synced, stable_n;
  logic [DEBOUNCE_BITS-1:0] cnt, cnt_n;
  db_state_t st, st_n;
  assign synced = s2 ^ INV;
  // synchronizer flops idle at the released level of the raw input
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, s2} <= {INV, INV};
    else {s1, s2} <= {raw, s1};
  // debouncer state, counter and accepted value
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= DB_STABLE;
      cnt <= '0;
      stable <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      stable <= stable_n;
    end
  // count while synced differs; flip on the last count, clear on any agreeing cycle
  always_comb begin
    st_n = DB_STABLE;
    cnt_n = '0;
    stable_n = stable;
    if (synced != stable) begin
      if ((st == DB_COUNTING ? cnt : '0) >= DEBOUNCE_CYCLES - 1'b1) stable_n = ~stable;
      else begin
        st_n = DB_COUNTING;
        cnt_n = cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mmio_controller.sv
// mmio_controller: decodes data-side accesses between data memory and board I/O registers
module mmio_controller
  import mmio_controller_pkg::*;
#(
  parameter int DBITS = 32,
  parameter int DEBOUNCE_BITS = 20,
  parameter logic [DEBOUNCE_BITS-1:0] DEBOUNCE_CYCLES = DEBOUNCE_BITS'(500000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] memAddr,
  input  logic             memRdEn,
  input  logic             memWrtEn,
  input  logic [DBITS-1:0] memWrtData,
  output logic [DBITS-1:0] memRdData,
  input  logic [DBITS-1:0] dmemRdData,
  output logic             dmemWrtEn,
  input  logic [SW_W-1:0]  sw,
  input  logic [KEY_W-1:0] key,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1,
  output logic [6:0]       hex2,
  output logic [6:0]       hex3,
  output logic [LEDR_W-1:0] ledr,
  output logic [LEDG_W-1:0] ledg
);
  logic [HEX_W-1:0] hex_r;
  logic [KEY_W-1:0] key_db;
  logic [SW_W-1:0] sw_db;
  logic hit_hex, hit_ledr, hit_ledg, hit_key, hit_sw, io_hit;
  logic unused_wdata;
  assign unused_wdata = ^memWrtData[DBITS-1:HEX_W];
  assign hit_hex  = memAddr == DBITS'(ADDR_HEX);
  assign hit_ledr = memAddr == DBITS'(ADDR_LEDR);
  assign hit_ledg = memAddr == DBITS'(ADDR_LEDG);
  assign hit_key  = memAddr == DBITS'(ADDR_KEY);
  assign hit_sw   = memAddr == DBITS'(ADDR_SW);
  assign io_hit = hit_hex | hit_ledr | hit_ledg | hit_key | hit_sw;
  assign dmemWrtEn = memWrtEn & ~io_hit;
  // zero-latency read mux; register reads see the pre-edge value
  always_comb
    memRdData = !memRdEn ? '0 :
                hit_hex  ? DBITS'(hex_r) :
                hit_ledr ? DBITS'(ledr) :
                hit_ledg ? DBITS'(ledg) :
                hit_key  ? DBITS'(key_db) :
                hit_sw   ? DBITS'(sw_db) : dmemRdData;
  // output device registers written by stores
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hex_r <= '0;
      ledr <= '0;
      ledg <= '0;
    end else if (memWrtEn) begin
      if (hit_hex) hex_r <= memWrtData[HEX_W-1:0];
      if (hit_ledr) ledr <= memWrtData[LEDR_W-1:0];
      if (hit_ledg) ledg <= memWrtData[LEDG_W-1:0];
    end
  assign hex0 = hex7(hex_r[3:0]);
  assign hex1 = hex7(hex_r[7:4]);
  assign hex2 = hex7(hex_r[11:8]);
  assign hex3 = hex7(hex_r[15:12]);
  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    mmio_controller_debouncer #(.DEBOUNCE_BITS(DEBOUNCE_BITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INV(1'b1))
      u_db (.clk(clk), .reset(reset), .raw(key[i]), .stable(key_db[i]));
  end
  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    mmio_controller_debouncer #(.DEBOUNCE_BITS(DEBOUNCE_BITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .INV(1'b0))
      u_db (.clk(clk), .reset(reset), .raw(sw[i]), .stable(sw_db[i]));
  end
endmodule

// File: tb/tb_mmio_controller.sv
// tb_mmio_controller: directed and randomized checks of mmio_controller against a behavioural model
module tb_mmio_controller;
  localparam logic [31:0] A_HEX  = 32'hF0000000;
  localparam logic [31:0] A_LEDR = 32'hF0000004;
  localparam logic [31:0] A_LEDG = 32'hF0000008;
  localparam logic [31:0] A_KEY  = 32'hF0000010;
  localparam logic [31:0] A_SW   = 32'hF0000014;
  localparam int DB = 4;
  localparam logic [6:0] GLYPH [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  logic clk = 1'b0;
  logic reset;
  logic [31:0] memAddr, memWrtData, memRdData, dmemRdData;
  logic memRdEn, memWrtEn, dmemWrtEn;
  logic [9:0] sw, ledr;
  logic [3:0] key;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [7:0] ledg;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  mmio_controller #(.DEBOUNCE_CYCLES(20'd4)) dut (
    .clk(clk), .reset(reset), .memAddr(memAddr), .memRdEn(memRdEn), .memWrtEn(memWrtEn),
    .memWrtData(memWrtData), .memRdData(memRdData), .dmemRdData(dmemRdData), .dmemWrtEn(dmemWrtEn),
    .sw(sw), .key(key), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .ledr(ledr), .ledg(ledg)
  );
  // reference model: registers plus per-bit "accept after DB consecutive differing synced samples"
  logic [15:0] m_hex;
  logic [9:0] m_ledr;
  logic [7:0] m_ledg;
  logic [13:0] m_d1, m_d2, m_stab;
  int m_run [14];
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_hex <= 0;
      m_ledr <= 0;
      m_ledg <= 0;
      m_d1 <= 0;
      m_d2 <= 0;
      m_stab <= 0;
      for (int i = 0; i < 14; i++) m_run[i] <= 0;
    end else begin
      if (memWrtEn && memAddr == A_HEX) m_hex <= memWrtData[15:0];
      if (memWrtEn && memAddr == A_LEDR) m_ledr <= memWrtData[9:0];
      if (memWrtEn && memAddr == A_LEDG) m_ledg <= memWrtData[7:0];
      m_d1 <= {sw, ~key};
      m_d2 <= m_d1;
      for (int i = 0; i < 14; i++)
        if (m_d2[i] != m_stab[i]) begin
          if (m_run[i] + 1 == DB) begin
            m_stab[i] <= ~m_stab[i];
            m_run[i] <= 0;
          end else m_run[i] <= m_run[i] + 1;
        end else m_run[i] <= 0;
    end
  function automatic logic is_io(input logic [31:0] a);
    return a == A_HEX || a == A_LEDR || a == A_LEDG || a == A_KEY || a == A_SW;
  endfunction
  function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic en, input logic [31:0] dm);
    if (!en) return 0;
    if (a == A_HEX) return {16'b0, m_hex};
    if (a == A_LEDR) return {22'b0, m_ledr};
    if (a == A_LEDG) return {24'b0, m_ledg};
    if (a == A_KEY) return {28'b0, m_stab[3:0]};
    if (a == A_SW) return {22'b0, m_stab[13:4]};
    return dm;
  endfunction
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle;
    memRdEn = 0;
    memWrtEn = 0;
    memAddr = 0;
    memWrtData = 0;
  endtask
  task automatic test_reset;
    idle();
    memWrtEn = 1;
    memAddr = A_LEDR;
    memWrtData = 32'h3FF;
    step();
    memWrtEn = 0;
    checks++;
    if (ledr !== 10'h3FF) begin failures++; $display("FAIL pre_reset_ledr got=%h exp=%h", ledr, 10'h3FF); end
    #2 reset = 1;
    #1;
    checks++;
    if (ledr !== 10'h0) begin failures++; $display("FAIL async_reset_ledr got=%h exp=0", ledr); end
    checks++;
    if ({hex3, hex2, hex1, hex0} !== {4{7'b1000000}})
      begin failures++; $display("FAIL async_reset_hex got=%h exp=%h", {hex3, hex2, hex1, hex0}, {4{7'b1000000}}); end
    checks++;
    if (ledg !== 8'h0) begin failures++; $display("FAIL async_reset_ledg got=%h exp=0", ledg); end
    @(negedge clk);
    reset = 0;
    step();
    memRdEn = 1;
    memAddr = A_KEY;
    #1;
    checks++;
    if (memRdData !== 32'h0) begin failures++; $display("FAIL reset_key_read got=%h exp=0", memRdData); end
    idle();
  endtask
  task automatic test_hex;
    dmemRdData = 32'hA5A5A5A5;
    memWrtEn = 1;
    memAddr = A_HEX;
    memWrtData = 32'h0000BEEF;
    #1;
    checks++;
    if (dmemWrtEn !== 1'b0) begin failures++; $display("FAIL hex_store_dmem_wen got=%b exp=0", dmemWrtEn); end
    step();
    memWrtEn = 0;
    checks++;
    if ({hex3, hex2, hex1, hex0} !== {GLYPH[11], GLYPH[14], GLYPH[14], GLYPH[15]})
      begin failures++; $display("FAIL hex_glyphs got=%h exp=%h", {hex3, hex2, hex1, hex0}, {GLYPH[11], GLYPH[14], GLYPH[14], GLYPH[15]}); end
    memRdEn = 1;
    #1;
    checks++;
    if (memRdData !== 32'h0000BEEF) begin failures++; $display("FAIL hex_load got=%h exp=%h", memRdData, 32'h0000BEEF); end
    memRdEn = 0;
    #1;
    checks++;
    if (memRdData !== 32'h0) begin failures++; $display("FAIL rden_low got=%h exp=0", memRdData); end
    idle();
  endtask
  task automatic test_dmem;
    dmemRdData = $urandom;
    memWrtEn = 1;
    memAddr = 32'h00000100;
    memWrtData = 32'h12345678;
    #1;
    checks++;
    if (dmemWrtEn !== 1'b1) begin failures++; $display("FAIL dmem_store_wen got=%b exp=1", dmemWrtEn); end
    step();
    memWrtEn = 0;
    checks++;
    if ({ledr, ledg, hex0} !== {10'h0, 8'h0, GLYPH[15]})
      begin failures++; $display("FAIL dmem_store_io_untouched got=%h exp=%h", {ledr, ledg, hex0}, {10'h0, 8'h0, GLYPH[15]}); end
    memRdEn = 1;
    #1;
    checks++;
    if (memRdData !== dmemRdData) begin failures++; $display("FAIL dmem_load got=%h exp=%h", memRdData, dmemRdData); end
    memAddr = 32'hF0000001;
    memWrtEn = 1;
    #1;
    checks++;
    if (memRdData !== dmemRdData || dmemWrtEn !== 1'b1)
      begin failures++; $display("FAIL near_miss_addr got=%h/%b exp=%h/1", memRdData, dmemWrtEn, dmemRdData); end
    idle();
  endtask
  task automatic test_rw_same;
    logic [31:0] v;
    v = $urandom | 32'h1;
    memRdEn = 1;
    memWrtEn = 1;
    memAddr = A_LEDG;
    memWrtData = v;
    #1;
    checks++;
    if (memRdData !== 32'h0) begin failures++; $display("FAIL rw_same_old got=%h exp=0", memRdData); end
    step();
    memWrtEn = 0;
    #1;
    checks++;
    if (memRdData !== {24'b0, v[7:0]}) begin failures++; $display("FAIL rw_same_new got=%h exp=%h", memRdData, {24'b0, v[7:0]}); end
    idle();
  endtask
  task automatic test_key;
    memRdEn = 1;
    memAddr = A_KEY;
    key[0] = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (memRdData !== (k >= 6 ? 32'h1 : 32'h0))
        begin failures++; $display("FAIL key_press_cycle%0d got=%h exp=%h", k, memRdData, (k >= 6 ? 32'h1 : 32'h0)); end
    end
    key[0] = 1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (memRdData !== (k >= 6 ? 32'h0 : 32'h1))
        begin failures++; $display("FAIL key_release_cycle%0d got=%h exp=%h", k, memRdData, (k >= 6 ? 32'h0 : 32'h1)); end
    end
    idle();
  endtask
  task automatic test_glitch;
    memRdEn = 1;
    memAddr = A_SW;
    sw[3] = 1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) sw[3] = 0;
      step();
      checks++;
      if (memRdData !== 32'h0) begin failures++; $display("FAIL sw_glitch_cycle%0d got=%h exp=0", k, memRdData); end
    end
    idle();
  endtask
  task automatic test_ro_store;
    memRdEn = 1;
    memWrtEn = 1;
    memAddr = A_SW;
    memWrtData = 32'hFF;
    #1;
    checks++;
    if (dmemWrtEn !== 1'b0) begin failures++; $display("FAIL sw_store_dmem_wen got=%b exp=0", dmemWrtEn); end
    step();
    memWrtEn = 0;
    #1;
    checks++;
    if (memRdData !== 32'h0) begin failures++; $display("FAIL sw_store_ignored got=%h exp=0", memRdData); end
    memAddr = A_KEY;
    memWrtEn = 1;
    #1;
    checks++;
    if (dmemWrtEn !== 1'b0) begin failures++; $display("FAIL key_store_dmem_wen got=%b exp=0", dmemWrtEn); end
    idle();
  endtask
  task automatic test_random;
    logic [31:0] a, e;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(7))
        0: a = A_HEX;
        1: a = A_LEDR;
        2: a = A_LEDG;
        3: a = A_KEY;
        4: a = A_SW;
        5: a = 32'hF000000C;
        default: a = $urandom;
      endcase
      memAddr = a;
      memRdEn = $urandom_range(1);
      memWrtEn = $urandom_range(1);
      memWrtData = $urandom;
      dmemRdData = $urandom;
      if ($urandom_range(15) == 0) key = 4'($urandom);
      if ($urandom_range(15) == 0) sw = 10'($urandom);
      #1;
      e = exp_rd(a, memRdEn, dmemRdData);
      checks++;
      if (memRdData !== e) begin failures++; $display("FAIL rand_rd n=%0d addr=%h got=%h exp=%h", n, a, memRdData, e); end
      checks++;
      if (dmemWrtEn !== (memWrtEn && !is_io(a)))
        begin failures++; $display("FAIL rand_dmem_wen n=%0d got=%b exp=%b", n, dmemWrtEn, memWrtEn && !is_io(a)); end
      step();
      checks++;
      if ({ledr, ledg} !== {m_ledr, m_ledg})
        begin failures++; $display("FAIL rand_leds n=%0d got=%h exp=%h", n, {ledr, ledg}, {m_ledr, m_ledg}); end
      checks++;
      if ({hex3, hex2, hex1, hex0} !== {GLYPH[m_hex[15:12]], GLYPH[m_hex[11:8]], GLYPH[m_hex[7:4]], GLYPH[m_hex[3:0]]})
        begin failures++; $display("FAIL rand_hex n=%0d got=%h model=%h", n, {hex3, hex2, hex1, hex0}, m_hex); end
    end
    idle();
  endtask
  initial begin
    reset = 1;
    key = 4'hF;
    sw = 0;
    dmemRdData = 0;
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    step();
    test_reset();
    test_hex();
    test_dmem();
    test_rw_same();
    test_key();
    test_glitch();
    test_ro_store();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mmio_controller.md
Name: mmio_controller

Overview:
- Data-side bus controller between the CPU's load/store stage, the data memory and the board I/O (KEY, SW, HEX, LEDR, LEDG).
- Decodes each access address. I/O addresses go to internal registers; all other addresses go to data memory.
- Holds the output device registers, synchronizes and debounces the KEY and SW inputs, and returns read data in the same cycle for the single-cycle datapath.

Parameters:
- DBITS, 32, data/address width
- ADDR_HEX, 32'hF0000000, HEX register (low 16 bits = 4 nibbles)
- ADDR_LEDR, 32'hF0000004, LEDR register (10 bits)
- ADDR_LEDG, 32'hF0000008, LEDG register (8 bits)
- ADDR_KEY, 32'hF0000010, debounced KEY state (read-only, 4 bits)
- ADDR_SW, 32'hF0000014, debounced SW state (read-only, 10 bits)
- DEBOUNCE_CYCLES, 20'd500000, consecutive stable cycles required to accept an input change
- DEBOUNCE_BITS, 20, debounce counter width

Ports:
- clk  in  1  system clock (PLL output)
- reset  in  1  asynchronous, active-high
- memAddr  in  DBITS  byte address from ALU
- memRdEn  in  1  load in progress
- memWrtEn  in  1  store in progress
- memWrtData  in  DBITS  store data
- memRdData  out  DBITS  load result to writeback mux
- dmemRdData  in  DBITS  data memory read port (combinational)
- dmemWrtEn  out  1  data memory write enable
- sw  in  10  raw switches
- key  in  4  raw keys, active-low
- hex0..hex3  out  7 each  seven-segment outputs, active-low, bit6 = segment g
- ledr  out  10  red LEDs
- ledg  out  8  green LEDs

Behaviour:
- Decode: ioHit when memAddr exactly equals one of the five I/O addresses (all 32 bits compared). Otherwise the access targets data memory.
- dmemWrtEn = memWrtEn & ~ioHit (combinational).
- Stores to HEX, LEDR and LEDG update the register at the rising clk edge, using the low bits of memWrtData (16, 10 and 8 bits).
- Stores to KEY or SW are ignored and are not forwarded to data memory.
- Reads are combinational, zero latency:
  - memRdEn=0 gives 0.
  - An I/O read returns the register value zero-extended.
  - Any other address returns dmemRdData.
- A simultaneous read and write to the same register returns the pre-edge (old) value.
- Output registers: ledr, ledg and the hex nibbles are driven directly from registers; hexN decodes nibble N (hex0 = bits 3:0).
- Hex decode is the standard 0–F glyph set, active-low: 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, F = 7'b0001110.
- Input path per bit (14 bits):
  - 2-flop synchronizer, then debouncer.
  - Keys are inverted after the synchronizer, so stable 1 = pressed.
- Debouncer states:
  - STABLE: synced == stable, counter held at 0.
  - COUNTING: synced != stable, counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable flips on that edge and the counter clears.
  - Any cycle with synced == stable during COUNTING returns to STABLE and clears the counter (glitch reject).
  - The counter saturates and never wraps; the parameter must be at least 1.
- Latency: a clean input change appears at the read port 2 + DEBOUNCE_CYCLES cycles after it reaches the first synchronizer flop.
- Reset values (asynchronous; also applies mid-operation):
  - hex register, ledr, ledg = 0; hex0..3 therefore show "0000" (7'b1000000 each).
  - Key synchronizer flops = 1 (released); SW synchronizer flops = 0.
  - Stable state = 0; counters = 0; debouncers in STABLE.
- Reset does not gate dmemWrtEn; the CPU holds memWrtEn low during reset.

Decomposition:
- Shared package holds the I/O address constants, field widths (HEX 16, LEDR 10, LEDG 8, KEY 4, SW 10) and the debouncer state encoding.
- One sub-module, debouncer:
  - single bit, parameterised by DEBOUNCE_CYCLES and DEBOUNCE_BITS, containing the synchronizer, counter and FSM;
  - instantiated 14 times.
- The hex glyph decode is a function, not a module.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset asserted mid-run with ledr=0x3FF -> ledr=0, hex0..3=7'b1000000 immediately, without waiting for a clock edge.
- Store 0x0000BEEF to 0xF0000000 -> next edge hex3..0 show B,E,E,F; dmemWrtEn stays 0; a load from the same address returns 0x0000BEEF.
- Store 0x12345678 to 0x00000100 -> dmemWrtEn=1, no I/O register changes; a load returns dmemRdData.
- key[0] driven low and held -> reading 0xF0000010 returns 0x1 exactly 6 cycles later; key[0] released -> returns 0x0 after 6 cycles.
- sw[3] pulsed high for 3 cycles -> SW read stays 0x000 throughout (glitch rejected).
- Store 0xFF to 0xF0000014 -> ignored; dmemWrtEn=0 and the SW read is unchanged.
